// File: rtl/ex_mem_pkg.sv
// Shared constants and types for the EX/MEM pipeline latch.
// Holds the widths, the RUN/HALTED state encoding and the overflow-count helper.
package ex_mem_pkg;

  localparam int DATA_W = 16;
  localparam int REG_W  = 3;
  localparam int CNT_W  = 8;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  // Saturating increment: the overflow count sticks at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
    return (val == CNT_MAX) ? val : val + 1'b1;
  endfunction

endpackage

// File: rtl/ex_mem_latch_dff_en16.sv
// 16-bit register with synchronous active-high reset and load enable.
// Used for the wide data fields of the EX/MEM latch.
module dff_en16
  import ex_mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/ex_mem_latch.sv
// EX/MEM pipeline latch with flush/stall, a sticky halt state and an overflow counter.
// Operand forwarding compare is built only when EX_FWD_EN is defined.
module ex_mem_latch
  import ex_mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_alu_out,
  input  logic              ex_ofl,
  input  logic [DATA_W-1:0] ex_st_data,
  input  logic [REG_W-1:0]  ex_wr_reg,
  input  logic              ex_reg_wr,
  input  logic              ex_mem_wr,
  input  logic              ex_mem_rd,
  input  logic              ex_halt,
  input  logic              stall,
  input  logic              flush,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  output logic              mem_valid,
  output logic [DATA_W-1:0] mem_alu_out,
  output logic              mem_ofl,
  output logic [DATA_W-1:0] mem_st_data,
  output logic [REG_W-1:0]  mem_wr_reg,
  output logic              mem_reg_wr,
  output logic              mem_mem_wr,
  output logic              mem_mem_rd,
  output logic              mem_halt,
  output logic              halted,
  output logic              fwd_a,
  output logic              fwd_b,
  output logic [CNT_W-1:0]  ofl_cnt
);

  genvar gi;

  state_t state_reg;
  logic   load;
  logic   bubble;

  // Bubble covers both an explicit flush and the halted state swallowing loads.
  assign bubble = flush | (~stall & (state_reg == HALTED));
  assign load   = ~flush & ~stall & (state_reg == RUN);
  assign halted = (state_reg == HALTED);

  logic [1:0][DATA_W-1:0] wide_d;
  logic [1:0][DATA_W-1:0] wide_q;

  assign wide_d[0]   = ex_alu_out;
  assign wide_d[1]   = ex_st_data;
  assign mem_alu_out = wide_q[0];
  assign mem_st_data = wide_q[1];

  for (gi = 0; gi < 2; gi++) begin : g_wide
    dff_en16 u_dff (
      .clk (clk),
      .rst (rst),
      .en  (load),
      .d   (wide_d[gi]),
      .q   (wide_q[gi])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= RUN;
      mem_valid  <= 1'b0;
      mem_ofl    <= 1'b0;
      mem_wr_reg <= '0;
      mem_reg_wr <= 1'b0;
      mem_mem_wr <= 1'b0;
      mem_mem_rd <= 1'b0;
      mem_halt   <= 1'b0;
      ofl_cnt    <= '0;
    end else if (bubble) begin
      mem_valid  <= 1'b0;
      mem_ofl    <= 1'b0;
      mem_reg_wr <= 1'b0;
      mem_mem_wr <= 1'b0;
      mem_mem_rd <= 1'b0;
      mem_halt   <= 1'b0;
    end else if (load) begin
      // Data is always captured; controls only survive for a valid instruction.
      mem_valid  <= ex_valid;
      mem_wr_reg <= ex_wr_reg;
      mem_ofl    <= ex_valid & ex_ofl;
      mem_reg_wr <= ex_valid & ex_reg_wr;
      mem_mem_wr <= ex_valid & ex_mem_wr;
      mem_mem_rd <= ex_valid & ex_mem_rd;
      mem_halt   <= ex_valid & ex_halt;
      if (ex_valid & ex_ofl) begin
        ofl_cnt <= sat_inc(ofl_cnt);
      end
      if (ex_valid & ex_halt) begin
        state_reg <= HALTED;
      end
    end
  end

`ifdef EX_FWD_EN
  logic [1:0][REG_W-1:0] id_src;
  logic [1:0]            fwd_vec;
  logic                  fwd_ok;

  assign id_src[0] = id_rs;
  assign id_src[1] = id_rt;
  // A load result is not available yet, so it never forwards from this stage.
  assign fwd_ok    = mem_valid & mem_reg_wr & ~mem_mem_rd;

  for (gi = 0; gi < 2; gi++) begin : g_fwd
    assign fwd_vec[gi] = fwd_ok & (mem_wr_reg == id_src[gi]);
  end

  assign fwd_a = fwd_vec[0];
  assign fwd_b = fwd_vec[1];
`else
  logic unused_fwd_ins;

  assign unused_fwd_ins = ^{id_rs, id_rt};
  assign fwd_a          = 1'b0;
  assign fwd_b          = 1'b0;
`endif

endmodule

// File: tb/tb_ex_mem_latch.sv
// Scoreboard bench for ex_mem_latch: the driver queues hand-computed expectations,
// a monitor pops and compares one entry per clock. Follows EX_FWD_EN for fwd expectations.
module tb_ex_mem_latch;

`ifdef EX_FWD_EN
  localparam logic FWD = 1'b1;
`else
  localparam logic FWD = 1'b0;
`endif

  typedef struct packed {
    logic        valid;
    logic [15:0] alu;
    logic        ofl;
    logic [15:0] st;
    logic [2:0]  wr;
    logic        rw;
    logic        mw;
    logic        mr;
    logic        halt;
    logic        halted;
    logic        fa;
    logic        fb;
    logic [7:0]  cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [15:0] ex_alu_out;
  logic        ex_ofl;
  logic [15:0] ex_st_data;
  logic [2:0]  ex_wr_reg;
  logic        ex_reg_wr;
  logic        ex_mem_wr;
  logic        ex_mem_rd;
  logic        ex_halt;
  logic        stall;
  logic        flush;
  logic [2:0]  id_rs;
  logic [2:0]  id_rt;
  logic        mem_valid;
  logic [15:0] mem_alu_out;
  logic        mem_ofl;
  logic [15:0] mem_st_data;
  logic [2:0]  mem_wr_reg;
  logic        mem_reg_wr;
  logic        mem_mem_wr;
  logic        mem_mem_rd;
  logic        mem_halt;
  logic        halted;
  logic        fwd_a;
  logic        fwd_b;
  logic [7:0]  ofl_cnt;

  int   errors = 0;
  int   checks = 0;
  int   txn    = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  ex_mem_latch dut (
    .clk         (clk),
    .rst         (rst),
    .ex_valid    (ex_valid),
    .ex_alu_out  (ex_alu_out),
    .ex_ofl      (ex_ofl),
    .ex_st_data  (ex_st_data),
    .ex_wr_reg   (ex_wr_reg),
    .ex_reg_wr   (ex_reg_wr),
    .ex_mem_wr   (ex_mem_wr),
    .ex_mem_rd   (ex_mem_rd),
    .ex_halt     (ex_halt),
    .stall       (stall),
    .flush       (flush),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .mem_valid   (mem_valid),
    .mem_alu_out (mem_alu_out),
    .mem_ofl     (mem_ofl),
    .mem_st_data (mem_st_data),
    .mem_wr_reg  (mem_wr_reg),
    .mem_reg_wr  (mem_reg_wr),
    .mem_mem_wr  (mem_mem_wr),
    .mem_mem_rd  (mem_mem_rd),
    .mem_halt    (mem_halt),
    .halted      (halted),
    .fwd_a       (fwd_a),
    .fwd_b       (fwd_b),
    .ofl_cnt     (ofl_cnt)
  );

  function automatic exp_t mk(input logic v, input logic [15:0] alu, input logic o,
                              input logic [15:0] st, input logic [2:0] wr,
                              input logic rw, input logic mw, input logic mr,
                              input logic h, input logic hd, input logic fa,
                              input logic fb, input logic [7:0] cnt);
    exp_t e;
    e.valid = v;  e.alu = alu; e.ofl = o;   e.st = st;   e.wr = wr;
    e.rw = rw;    e.mw = mw;   e.mr = mr;   e.halt = h;  e.halted = hd;
    e.fa = fa;    e.fb = fb;   e.cnt = cnt;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL txn %0d %s: got %h expected %h", txn, nm, act, req);
    end
  endtask

  // One clock of stimulus; e is what the outputs must show after the next rising edge.
  task automatic cyc(input logic r, input logic s, input logic f, input logic v,
                     input logic [15:0] alu, input logic o, input logic [15:0] st,
                     input logic [2:0] wr, input logic rw, input logic mw,
                     input logic mr, input logic h, input logic [2:0] rs,
                     input logic [2:0] rt, input exp_t e);
    @(negedge clk);
    rst = r;  stall = s;  flush = f;  ex_valid = v;  ex_alu_out = alu;  ex_ofl = o;
    ex_st_data = st;  ex_wr_reg = wr;  ex_reg_wr = rw;  ex_mem_wr = mw;
    ex_mem_rd = mr;  ex_halt = h;  id_rs = rs;  id_rt = rt;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("mem_valid",   {15'd0, mem_valid},  {15'd0, e.valid});
        chk("mem_alu_out", mem_alu_out,          e.alu);
        chk("mem_ofl",     {15'd0, mem_ofl},    {15'd0, e.ofl});
        chk("mem_st_data", mem_st_data,          e.st);
        chk("mem_wr_reg",  {13'd0, mem_wr_reg}, {13'd0, e.wr});
        chk("mem_reg_wr",  {15'd0, mem_reg_wr}, {15'd0, e.rw});
        chk("mem_mem_wr",  {15'd0, mem_mem_wr}, {15'd0, e.mw});
        chk("mem_mem_rd",  {15'd0, mem_mem_rd}, {15'd0, e.mr});
        chk("mem_halt",    {15'd0, mem_halt},   {15'd0, e.halt});
        chk("halted",      {15'd0, halted},     {15'd0, e.halted});
        chk("fwd_a",       {15'd0, fwd_a},      {15'd0, e.fa});
        chk("fwd_b",       {15'd0, fwd_b},      {15'd0, e.fb});
        chk("ofl_cnt",     {8'd0, ofl_cnt},     {8'd0, e.cnt});
        $display("txn %0d: valid=%b alu=%h st=%h wr=%0d halt=%b halted=%b fwd=%b%b cnt=%0d errors=%0d",
                 txn, mem_valid, mem_alu_out, mem_st_data, mem_wr_reg, mem_halt,
                 halted, fwd_a, fwd_b, ofl_cnt, errors);
        txn++;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : driver
    int waited;
    rst = 1'b1;  stall = 1'b0;  flush = 1'b0;  ex_valid = 1'b0;  ex_alu_out = '0;
    ex_ofl = 1'b0;  ex_st_data = '0;  ex_wr_reg = '0;  ex_reg_wr = 1'b0;
    ex_mem_wr = 1'b0;  ex_mem_rd = 1'b0;  ex_halt = 1'b0;  id_rs = '0;  id_rt = '0;

    // r  s  f  v  alu       o  st        wr  rw mw mr h  rs rt
    cyc(1, 0, 1, 1, 16'hAAAA, 1, 16'h5555, 3'd7, 1, 1, 1, 1, 3'd7, 3'd7,
        mk(0, 16'h0000, 0, 16'h0000, 3'd0, 0, 0, 0, 0, 0, 0, 0, 8'd0));
    cyc(0, 0, 0, 1, 16'h1234, 0, 16'h00AA, 3'd3, 1, 0, 0, 0, 3'd3, 3'd0,
        mk(1, 16'h1234, 0, 16'h00AA, 3'd3, 1, 0, 0, 0, 0, FWD, 0, 8'd0));
    for (int k = 0; k < 3; k++) begin
      cyc(0, 1, 0, 1, 16'hFFFF - 16'(k), 1, 16'h1111, 3'd5, 0, 1, 0, 1, 3'd3, 3'd0,
          mk(1, 16'h1234, 0, 16'h00AA, 3'd3, 1, 0, 0, 0, 0, FWD, 0, 8'd0));
    end
    cyc(0, 1, 1, 1, 16'h5555, 1, 16'h6666, 3'd3, 1, 0, 0, 0, 3'd3, 3'd0,
        mk(0, 16'h1234, 0, 16'h00AA, 3'd3, 0, 0, 0, 0, 0, 0, 0, 8'd0));
    cyc(0, 0, 0, 0, 16'h2222, 1, 16'h3333, 3'd6, 1, 1, 1, 1, 3'd6, 3'd6,
        mk(0, 16'h2222, 0, 16'h3333, 3'd6, 0, 0, 0, 0, 0, 0, 0, 8'd0));
    cyc(0, 0, 0, 1, 16'h4444, 1, 16'h0000, 3'd2, 1, 0, 1, 0, 3'd2, 3'd2,
        mk(1, 16'h4444, 1, 16'h0000, 3'd2, 1, 0, 1, 0, 0, 0, 0, 8'd1));
    cyc(0, 0, 0, 1, 16'h0010, 0, 16'hBEEF, 3'd7, 1, 1, 0, 0, 3'd0, 3'd7,
        mk(1, 16'h0010, 0, 16'hBEEF, 3'd7, 1, 1, 0, 0, 0, 0, FWD, 8'd1));
    cyc(0, 0, 1, 1, 16'h9999, 1, 16'h0001, 3'd5, 1, 0, 0, 1, 3'd0, 3'd7,
        mk(0, 16'h0010, 0, 16'hBEEF, 3'd7, 0, 0, 0, 0, 0, 0, 0, 8'd1));
    cyc(0, 0, 0, 1, 16'h0ABC, 0, 16'h0000, 3'd1, 0, 0, 0, 1, 3'd1, 3'd1,
        mk(1, 16'h0ABC, 0, 16'h0000, 3'd1, 0, 0, 0, 1, 1, 0, 0, 8'd1));
    for (int k = 0; k < 2; k++) begin
      cyc(0, 0, 0, 1, 16'h1357, 1, 16'h2468, 3'd4, 1, 0, 0, 0, 3'd4, 3'd4,
          mk(0, 16'h0ABC, 0, 16'h0000, 3'd1, 0, 0, 0, 0, 1, 0, 0, 8'd1));
    end
    cyc(1, 1, 0, 1, 16'h7777, 1, 16'h7777, 3'd4, 1, 0, 0, 0, 3'd4, 3'd4,
        mk(0, 16'h0000, 0, 16'h0000, 3'd0, 0, 0, 0, 0, 0, 0, 0, 8'd0));
    cyc(0, 0, 0, 1, 16'hCAFE, 0, 16'h0001, 3'd4, 1, 0, 0, 0, 3'd4, 3'd4,
        mk(1, 16'hCAFE, 0, 16'h0001, 3'd4, 1, 0, 0, 0, 0, FWD, FWD, 8'd0));

    for (int i = 0; i < 260; i++) begin
      cyc(0, 0, 0, 1, 16'(i), 1, 16'h0000, 3'd0, 0, 0, 0, 0, 3'd0, 3'd0,
          mk(1, 16'(i), 1, 16'h0000, 3'd0, 0, 0, 0, 0, 0, 0, 0,
             (i < 255) ? 8'(i + 1) : 8'hFF));
    end
    cyc(0, 1, 0, 1, 16'h8888, 1, 16'h8888, 3'd2, 1, 0, 0, 0, 3'd0, 3'd0,
        mk(1, 16'h0103, 1, 16'h0000, 3'd0, 0, 0, 0, 0, 0, 0, 0, 8'hFF));
    cyc(0, 0, 1, 1, 16'h8888, 1, 16'h8888, 3'd2, 1, 0, 0, 0, 3'd0, 3'd0,
        mk(0, 16'h0103, 0, 16'h0000, 3'd0, 0, 0, 0, 0, 0, 0, 0, 8'hFF));

    waited = 0;
    while (exp_q.size() != 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    #2;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending entries expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_mem_latch.md
EX_MEM_LATCH -- requirements
Module: ex_mem_latch

Interface
REQ-001 SHALL have clk, input, 1, the single rising-edge clock.
REQ-002 SHALL have rst, input, 1, a synchronous active-high reset.
REQ-003 SHALL have ex_valid, input, 1, execute-stage instruction valid.
REQ-004 SHALL have ex_alu_out, input, 16, the ALU result.
REQ-005 SHALL have ex_ofl, input, 1, the ALU overflow flag.
REQ-006 SHALL have ex_st_data, input, 16, store data.
REQ-007 SHALL have ex_wr_reg, input, 3, destination register.
REQ-008 SHALL have ex_reg_wr, ex_mem_wr, ex_mem_rd and ex_halt, each an input of width 1, as control bits.
REQ-009 SHALL have stall and flush, each an input of width 1, as hazard-unit controls.
REQ-010 SHALL have id_rs and id_rt, each an input of width 3, as decode-stage source registers for the forwarding compare.
REQ-011 SHALL have mem_valid, mem_alu_out[16], mem_ofl, mem_st_data[16], mem_wr_reg[3], mem_reg_wr, mem_mem_wr, mem_mem_rd and mem_halt as outputs, each the registered copy of its ex_ counterpart.
REQ-012 SHALL have halted, output, 1, set once a halt instruction has been latched.
REQ-013 SHALL have fwd_a and fwd_b, each an output of width 1, as forward-select outputs for ALU operands A and B.
REQ-014 SHALL have ofl_cnt, output, 8, a saturating count of overflowing instructions.

Function
REQ-015 SHALL resolve each rising clk edge with priority rst > flush > stall > halted-bubble > load.
REQ-016 SHALL, on flush, clear mem_valid and all control bits (reg_wr, mem_wr, mem_rd, halt, ofl) and leave the data fields unchanged.
REQ-017 SHALL, on stall without flush, hold every register, including ofl_cnt and the state.
REQ-018 SHALL, on load, capture all ex_ fields with 1-cycle latency; when ex_valid=0 it captures the data but forces controls and mem_valid to 0.
REQ-019 SHALL implement two states, RUN and HALTED: RUN goes to HALTED on a load with ex_valid=1 and ex_halt=1; HALTED is left only by rst.
REQ-020 SHALL, in HALTED, replace each load with a bubble (as on flush), so mem_halt is high for exactly one cycle and halted stays high.
REQ-021 SHALL increment ofl_cnt on a load with ex_valid=1 and ex_ofl=1, saturating at 8'hFF with no wrap.
REQ-022 SHALL NOT change ofl_cnt on flush, stall or a bubble.
REQ-023 SHALL drive fwd_a = mem_valid & mem_reg_wr & ~mem_mem_rd & (mem_wr_reg==id_rs), and fwd_b the same with id_rt, combinationally from registered state.
REQ-024 SHALL, when stall and flush are both high, behave as flush.
REQ-025 SHALL, when ex_halt and flush occur in the same cycle, not enter HALTED.

Reset
REQ-026 SHALL, on rst, clear every output register to 0, ofl_cnt to 0 and the state to RUN, overriding flush and stall, including when a reset arrives mid-stall or in HALTED.

Configuration
REQ-027 SHALL provide forwarding logic per REQ-023 only when EX_FWD_EN is defined.
REQ-028 SHALL, when EX_FWD_EN is undefined, tie fwd_a and fwd_b to 0 and synthesize no comparators.

Structure
REQ-029 SHALL take its shared constants (data width 16, register-index width 3, state encodings RUN=1'b0 and HALTED=1'b1, ofl_cnt width 8) from the shared ex_mem package.
REQ-030 SHALL instantiate one sub-module, dff_en16, a 16-bit sync-reset enable register, for mem_alu_out and mem_st_data.

Verification
REQ-031 SHALL be verified with: load ex_valid=1, ex_alu_out=16'h1234, ex_wr_reg=3, ex_reg_wr=1 -> next cycle mem_alu_out=16'h1234, mem_valid=1, and with id_rs=3, fwd_a=1 (EX_FWD_EN defined) or 0 (undefined).
REQ-032 SHALL be verified with: stall for 3 cycles while the ex_ inputs change -> outputs hold their pre-stall values; flush+stall together -> mem_valid=0 and mem_reg_wr=0.
REQ-033 SHALL be verified with: a valid halt latched -> mem_halt=1 for 1 cycle, halted=1 persists, and later valid instructions give mem_valid=0; halt+flush together -> halted stays 0.
REQ-034 SHALL be verified with: 260 consecutive valid ex_ofl=1 loads -> ofl_cnt=8'hFF with no wrap; an ex_ofl=1 load under flush -> count unchanged.
REQ-035 SHALL be verified with: mem_mem_rd=1 and matching id_rt -> fwd_b=0; rst asserted in HALTED -> all outputs 0, halted=0, and a load on the next cycle proceeds normally.
